// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - multi-frame sprite blitter with positioning, transparency keying and clipping
// Walks one frame of the sprite ROM in raster order and emits one VGA plot candidate per cycle.
module sprite_blitter #(
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int FRAMES     = 1,
    parameter int COLOR_BITS = 3,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter logic [COLOR_BITS-1:0] TRANSPARENT = '0,
    parameter MIF_FILE = "UNUSED",
    parameter logic [FRAMES*SPRITE_W*SPRITE_H*COLOR_BITS-1:0] ROM_INIT = '0,
    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [X_BITS-1:0]     pos_x,
    input  logic [Y_BITS-1:0]     pos_y,
    input  logic [FRAME_W-1:0]    frame,
    output logic                  busy,
    output logic                  done,
    output logic                  plot,
    output logic [X_BITS-1:0]     vga_x,
    output logic [Y_BITS-1:0]     vga_y,
    output logic [COLOR_BITS-1:0] vga_color
);

    localparam int N_PIX  = SPRITE_W * SPRITE_H;
    localparam int DEPTH  = FRAMES * N_PIX;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SX_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int SY_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_sx_end;
    logic                  w_last_pix;
    logic [FRAME_W-1:0]    w_frame_clamped;
    logic [ADDR_W-1:0]     w_addr;
    logic [X_BITS:0]       w_x;
    logic [Y_BITS:0]       w_y;
    logic                  w_inb;

    logic [X_BITS-1:0]     r_pos_x;
    logic [Y_BITS-1:0]     r_pos_y;
    logic [FRAME_W-1:0]    r_frame;
    logic [SX_W-1:0]       r_sx;
    logic [SY_W-1:0]       r_sy;

    logic                  r_valid;
    logic                  r_inb;
    logic                  r_done;
    logic [X_BITS-1:0]     r_x;
    logic [Y_BITS-1:0]     r_y;
    logic [COLOR_BITS-1:0] r_rom_q;

    assign w_sx_end   = (r_sx == SX_W'(SPRITE_W - 1));
    assign w_last_pix = w_sx_end && (r_sy == SY_W'(SPRITE_H - 1));
    assign w_frame_clamped = ({1'b0, frame} >= (FRAME_W + 1)'(FRAMES)) ? FRAME_W'(FRAMES - 1) : frame;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_issue  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_issue = 1'b1;
                if (w_last_pix) begin
                    w_next = S_FLUSH;
                end
            end
            // One cycle lets the final ROM word and its coordinates reach the outputs.
            S_FLUSH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_frame <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
        end else if (w_accept) begin
            r_pos_x <= pos_x;
            r_pos_y <= pos_y;
            r_frame <= w_frame_clamped;
            r_sx    <= '0;
            r_sy    <= '0;
        end else if (w_issue) begin
            if (w_sx_end) begin
                r_sx <= '0;
                r_sy <= r_sy + SY_W'(1);
            end else begin
                r_sx <= r_sx + SX_W'(1);
            end
        end
    end

    assign w_addr = ADDR_W'(int'(r_frame) * N_PIX + int'(r_sy) * SPRITE_W + int'(r_sx));

    // The extra MSB keeps off-screen sums from wrapping back onto the screen.
    assign w_x   = (X_BITS + 1)'(r_pos_x) + (X_BITS + 1)'(r_sx);
    assign w_y   = (Y_BITS + 1)'(r_pos_y) + (Y_BITS + 1)'(r_sy);
    assign w_inb = (w_x < (X_BITS + 1)'(SCREEN_W)) && (w_y < (Y_BITS + 1)'(SCREEN_H));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_inb   <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_valid <= w_issue;
            r_done  <= (r_state == S_FLUSH);
            if (w_issue) begin
                r_x   <= w_x[X_BITS-1:0];
                r_y   <= w_y[Y_BITS-1:0];
                r_inb <= w_inb;
            end
        end
    end

    generate
        if (MIF_FILE == "UNUSED") begin : g_param_rom
            logic [COLOR_BITS-1:0] w_rom [DEPTH];
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
                assign w_rom[gi] = ROM_INIT[gi*COLOR_BITS +: COLOR_BITS];
            end
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_rom_q <= '0;
                end else if (w_issue) begin
                    r_rom_q <= w_rom[w_addr];
                end
            end
        end else begin : g_mif_rom
            (* ram_init_file = MIF_FILE *) logic [COLOR_BITS-1:0] r_mem [DEPTH];
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_rom_q <= '0;
                end else if (w_issue) begin
                    r_rom_q <= r_mem[w_addr];
                end
            end
        end
    endgenerate

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign plot      = r_valid && r_inb && (r_rom_q != TRANSPARENT);
    assign vga_x     = r_x;
    assign vga_y     = r_y;
    assign vga_color = r_rom_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - sprite_blitter bench: directed scenarios plus randomized traffic against a raster model
module tb_sprite_blitter;

    localparam int SW  = 4;
    localparam int SH  = 2;
    localparam int NF  = 3;
    localparam int CB  = 4;
    localparam int SCW = 160;
    localparam int SCH = 120;
    localparam int N   = SW * SH;
    // frame0 = 1..8, frame1 = 1,0,3,4,5,0,7,8, frame2 = 9..15,2 (entry 0 in the LSBs)
    localparam logic [NF*N*CB-1:0] ROM_BITS = {32'h2FEDCBA9, 32'h87054301, 32'h87654321};

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    pos_x = '0;
    logic [6:0]    pos_y = '0;
    logic [1:0]    frame = '0;
    logic          busy;
    logic          done;
    logic          plot;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [CB-1:0] vga_color;

    sprite_blitter #(
        .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(NF), .COLOR_BITS(CB),
        .SCREEN_W(SCW), .SCREEN_H(SCH), .X_BITS(8), .Y_BITS(7),
        .TRANSPARENT(4'd0), .MIF_FILE("UNUSED"), .ROM_INIT(ROM_BITS)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .pos_x(pos_x), .pos_y(pos_y), .frame(frame),
        .busy(busy), .done(done), .plot(plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int rom_m [NF*N];
    bit acc_valid = 1'b0;
    int acc_cyc, acc_px, acc_py, acc_f;
    bit seen_pix = 1'b0;
    int plot_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < NF*N; i++) rom_m[i] = int'(ROM_BITS[i*CB +: CB]);
    end

    // Raster model: every output is derived from the cycle offset since the accepted start.
    always @(negedge clk) begin : cmp
        int d, k, ex, ey, ec;
        bit eb, ed, win, ep;
        if (!resetn) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_plot", int'(plot), 0);
            chk("rst_x", int'(vga_x), 0);
            chk("rst_y", int'(vga_y), 0);
            chk("rst_color", int'(vga_color), 0);
            acc_valid = 1'b0;
            seen_pix  = 1'b0;
        end else begin
            d   = acc_valid ? (cyc - acc_cyc) : -1;
            eb  = acc_valid && d >= 1 && d <= N + 1;
            ed  = acc_valid && d == N + 2;
            win = acc_valid && d >= 2 && d <= N + 1;
            chk("busy", int'(busy), int'(eb));
            chk("done", int'(done), int'(ed));
            if (win) begin
                k  = d - 2;
                ex = acc_px + k % SW;
                ey = acc_py + k / SW;
                ec = rom_m[acc_f * N + k];
                ep = (ec != 0) && (ex < SCW) && (ey < SCH);
                chk("plot", int'(plot), int'(ep));
                chk("vga_x", int'(vga_x), ex % 256);
                chk("vga_y", int'(vga_y), ey % 128);
                chk("vga_color", int'(vga_color), ec);
                seen_pix = 1'b1;
                if (plot) plot_cnt++;
            end else begin
                chk("plot_idle", int'(plot), 0);
                if (!seen_pix) begin
                    chk("idle_x", int'(vga_x), 0);
                    chk("idle_y", int'(vga_y), 0);
                    chk("idle_color", int'(vga_color), 0);
                end
            end
            if (start && !eb) begin
                acc_valid = 1'b1;
                acc_cyc   = cyc;
                acc_px    = int'(pos_x);
                acc_py    = int'(pos_y);
                acc_f     = (int'(frame) >= NF) ? NF - 1 : int'(frame);
            end
        end
    end

    task automatic goto_neg(input int t);
        while (!(cyc >= t && clk == 1'b0)) @(negedge clk);
    endtask

    task automatic goto_pos(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scramble();
        pos_x = 8'($urandom_range(255));
        pos_y = 7'($urandom_range(127));
        frame = 2'($urandom_range(3));
    endtask

    task automatic fire(input int px, input int py, input int f, output int t0);
        start = 1'b1;
        pos_x = 8'(px);
        pos_y = 7'(py);
        frame = 2'(f);
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
    endtask

    task automatic scen_basic();
        int t0;
        fire(10, 20, 0, t0);
        goto_neg(t0 + 1);
        chk("a_busy1", int'(busy), 1);
        chk("a_plot1", int'(plot), 0);
        goto_neg(t0 + 2);
        chk("a_first_plot", int'(plot), 1);
        chk("a_first_x", int'(vga_x), 10);
        chk("a_first_y", int'(vga_y), 20);
        chk("a_first_c", int'(vga_color), 1);
        goto_neg(t0 + 9);
        chk("a_last_plot", int'(plot), 1);
        chk("a_last_x", int'(vga_x), 13);
        chk("a_last_y", int'(vga_y), 21);
        chk("a_last_c", int'(vga_color), 8);
        goto_neg(t0 + 10);
        chk("a_done", int'(done), 1);
        chk("a_busy_end", int'(busy), 0);
        chk("a_plot_end", int'(plot), 0);
        goto_pos(t0 + 12);
    endtask

    initial begin : stim
        int t0, t1, tx, p0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_plot", int'(plot), 0);
        resetn = 1'b1;
        goto_pos(cyc + 2);

        scen_basic();

        // Transparent pixels 1 and 5 drop out without disturbing the cadence.
        p0 = plot_cnt;
        fire(30, 40, 1, t0);
        goto_neg(t0 + 3);
        chk("t_pix1_plot", int'(plot), 0);
        goto_neg(t0 + 7);
        chk("t_pix5_plot", int'(plot), 0);
        goto_neg(t0 + 10);
        chk("t_done", int'(done), 1);
        chk("t_plots", plot_cnt - p0, 6);
        goto_pos(t0 + 11);

        p0 = plot_cnt;
        fire(158, 119, 0, t0);
        goto_neg(t0 + 3);
        chk("c_x159_plot", int'(plot), 1);
        chk("c_x159_x", int'(vga_x), 159);
        goto_neg(t0 + 4);
        chk("c_x160_plot", int'(plot), 0);
        chk("c_x160_x", int'(vga_x), 160);
        goto_neg(t0 + 10);
        chk("c_plots", plot_cnt - p0, 2);
        goto_pos(t0 + 11);

        // Frame 2 then an out-of-range frame accepted right in the done cycle.
        fire(0, 0, 2, t0);
        goto_neg(t0 + 2);
        chk("f2_first_c", int'(vga_color), 9);
        goto_neg(t0 + 9);
        chk("f2_last_c", int'(vga_color), 2);
        goto_pos(t0 + 10);
        fire(0, 0, 3, t1);
        goto_neg(t0 + 12);
        chk("f3_first_c", int'(vga_color), 9);
        chk("f3_first_plot", int'(plot), 1);
        goto_neg(t1 + 9);
        chk("f3_last_c", int'(vga_color), 2);
        goto_pos(t1 + 11);

        fire(50, 50, 0, t0);
        goto_pos(t0 + 3);
        fire(60, 60, 1, tx);
        goto_neg(t0 + 5);
        chk("s_ignored_x", int'(vga_x), 53);
        chk("s_ignored_c", int'(vga_color), 4);
        goto_pos(t0 + 10);
        fire(70, 30, 0, t1);
        goto_neg(t0 + 11);
        chk("s_gap_plot", int'(plot), 0);
        goto_neg(t0 + 12);
        chk("s_second_plot", int'(plot), 1);
        chk("s_second_x", int'(vga_x), 70);
        chk("s_second_y", int'(vga_y), 30);
        goto_pos(t1 + 12);

        fire(10, 20, 0, t0);
        goto_pos(t0 + 5);
        resetn = 1'b0;
        #1;
        chk("r_busy", int'(busy), 0);
        chk("r_plot", int'(plot), 0);
        chk("r_x", int'(vga_x), 0);
        chk("r_y", int'(vga_y), 0);
        chk("r_color", int'(vga_color), 0);
        goto_pos(t0 + 6);
        resetn = 1'b1;
        goto_pos(t0 + 16);
        scen_basic();

        for (int i = 0; i < 900; i++) begin
            start = ($urandom_range(3) == 0);
            if ($urandom_range(1) == 1) pos_x = 8'($urandom_range(255, 150));
            else pos_x = 8'($urandom_range(255));
            if ($urandom_range(1) == 1) pos_y = 7'($urandom_range(127, 110));
            else pos_y = 7'($urandom_range(127));
            frame = 2'($urandom_range(3));
            resetn = ($urandom_range(299) != 0);
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        resetn = 1'b1;
        goto_pos(cyc + 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
